// File: rtl/second_chance_pkg.sv
// Shared types and one-hot helpers for the second-chance slot selector.
package second_chance_pkg;

  // Helpers work on a fixed wide vector; callers size-cast to their slot count.
  localparam int MAX_N = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    SWEEP   = 2'd2,
    DONE    = 2'd3
  } sc_state_e;

  function automatic logic [MAX_N-1:0] onehot_lowest(input logic [MAX_N-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  function automatic logic [MAX_N-1:0] index_to_onehot(input int unsigned idx,
                                                       input int unsigned n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (idx < n) r = MAX_N'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/sc_priority_onehot.sv
// Lowest-index-wins one-hot picker with an "any set" flag.
module sc_priority_onehot
  import second_chance_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot,
  output logic             any
);

  assign onehot = WIDTH'(onehot_lowest(MAX_N'(vec)));
  assign any    = |vec;

endmodule

// File: rtl/second_chance_select.sv
// Hit / free-slot / clock-hand victim selection driving the bucket mux one-hot select.
module second_chance_select
  import second_chance_pkg::*;
#(
  parameter int KEY_WIDTH   = 32,
  parameter int BUCKET_SIZE = 1,
  parameter int DATA_LINES  = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [KEY_WIDTH-1:0]                                  in_key,
  input  logic [DATA_LINES-1:0][BUCKET_SIZE-1:0][KEY_WIDTH-1:0] in_slot_key,
  input  logic [DATA_LINES-1:0][BUCKET_SIZE-1:0]                in_slot_valid,
  input  logic [DATA_LINES-1:0][BUCKET_SIZE-1:0]                in_slot_ref,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [DATA_LINES-1:0][BUCKET_SIZE-1:0]                out_sel,
  output logic                                                  out_hit,
  output logic                                                  out_evict,
  output logic [DATA_LINES-1:0][BUCKET_SIZE-1:0]                out_ref_clear
);

  localparam int N      = DATA_LINES * BUCKET_SIZE;
  localparam int HAND_W = (N > 1) ? $clog2(N) : 1;

  sc_state_e state, state_d;
  logic [HAND_W-1:0] hand, hand_d, hand_inc;

  // Packed [line][bucket] layout flattens to bit k = line*BUCKET_SIZE + bucket.
  logic [KEY_WIDTH-1:0]        key_q;
  logic [N-1:0][KEY_WIDTH-1:0] slot_key_q;
  logic [N-1:0]                valid_q, ref_q, ref_d;

  logic [N-1:0] match, match_oh, free_oh, hand_oh;
  logic         any_match, any_free;
  logic [N-1:0] sel_d, clr_d;
  logic         hit_d, evict_d;
  logic         accept;

  for (genvar k = 0; k < N; k++) begin : g_match
    assign match[k] = valid_q[k] && (slot_key_q[k] == key_q);
  end

  sc_priority_onehot #(.WIDTH(N)) u_match_pick (
    .vec    (match),
    .onehot (match_oh),
    .any    (any_match)
  );

  sc_priority_onehot #(.WIDTH(N)) u_free_pick (
    .vec    (~valid_q),
    .onehot (free_oh),
    .any    (any_free)
  );

  // N need not be a power of two, so wrap explicitly instead of relying on overflow.
  assign hand_inc  = (hand == HAND_W'(N - 1)) ? '0 : hand + 1'b1;
  assign hand_oh   = N'(index_to_onehot(32'(hand), N));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;

  always_comb begin
    state_d = state;
    hand_d  = hand;
    ref_d   = ref_q;
    sel_d   = out_sel;
    hit_d   = out_hit;
    evict_d = out_evict;
    clr_d   = out_ref_clear;
    case (state)
      IDLE: begin
        if (in_valid) begin
          clr_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        hit_d   = 1'b0;
        evict_d = 1'b0;
        if (any_match) begin
          sel_d   = match_oh;
          hit_d   = 1'b1;
          state_d = DONE;
        end else if (any_free) begin
          sel_d   = free_oh;
          state_d = DONE;
        end else begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        hand_d = hand_inc;
        if (ref_q[hand]) begin
          ref_d[hand] = 1'b0;
          clr_d[hand] = 1'b1;
        end else begin
          sel_d   = hand_oh;
          evict_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hand          <= '0;
      out_sel       <= '0;
      out_hit       <= 1'b0;
      out_evict     <= 1'b0;
      out_ref_clear <= '0;
      key_q         <= '0;
      slot_key_q    <= '0;
      valid_q       <= '0;
      ref_q         <= '0;
    end else begin
      state         <= state_d;
      hand          <= hand_d;
      out_sel       <= sel_d;
      out_hit       <= hit_d;
      out_evict     <= evict_d;
      out_ref_clear <= clr_d;
      if (accept) begin
        key_q      <= in_key;
        slot_key_q <= in_slot_key;
        valid_q    <= in_slot_valid;
        ref_q      <= in_slot_ref;
      end else begin
        ref_q      <= ref_d;
      end
    end
  end

endmodule

// File: tb/tb_second_chance_select.sv
// Directed + random checks of second_chance_select against a slot-level behavioural model.
module tb_second_chance_select;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: 4 lines x 1 bucket
  logic                  in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0]           in_key = '0;
  logic [3:0][0:0][31:0] skey = '0;
  logic [3:0][0:0]       svld = '0, sref = '0;
  logic [3:0][0:0]       out_sel, out_clr;
  logic                  out_hit, out_evict;

  // Three-line instance to exercise non-power-of-two hand wrap
  logic                  in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0;
  logic [31:0]           in_key3 = '0;
  logic [2:0][0:0][31:0] skey3 = '0;
  logic [2:0][0:0]       svld3 = '0, sref3 = '0;
  logic [2:0][0:0]       out_sel3, out_clr3;
  logic                  out_hit3, out_evict3;

  int checks = 0;
  int failures = 0;
  int m_hand = 0;

  second_chance_select #(.KEY_WIDTH(32), .BUCKET_SIZE(1), .DATA_LINES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .in_slot_key(skey), .in_slot_valid(svld), .in_slot_ref(sref),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_hit(out_hit),
    .out_evict(out_evict), .out_ref_clear(out_clr)
  );

  second_chance_select #(.KEY_WIDTH(32), .BUCKET_SIZE(1), .DATA_LINES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_key(in_key3),
    .in_slot_key(skey3), .in_slot_valid(svld3), .in_slot_ref(sref3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3), .out_hit(out_hit3),
    .out_evict(out_evict3), .out_ref_clear(out_clr3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One lookup on the 4-slot instance; expected result comes from walking the slot rules.
  task automatic lookup(input logic [31:0] key, input logic [3:0][31:0] keys,
                        input logic [3:0] vld, input logic [3:0] rf, input int hold);
    logic [3:0] e_sel, e_clr, r;
    logic       e_hit, e_evict;
    int         e_lat, lat, s, h;
    bit         found;
    e_sel = '0; e_clr = '0; e_hit = 0; e_evict = 0; found = 0; e_lat = 2;
    for (int k = 0; k < 4; k++)
      if (!found && vld[k] && keys[k] == key) begin
        e_sel[k] = 1; e_hit = 1; found = 1;
      end
    for (int k = 0; k < 4; k++)
      if (!found && !vld[k]) begin
        e_sel[k] = 1; found = 1;
      end
    if (!found) begin
      r = rf; s = 0; h = m_hand;
      while (!found) begin
        s++;
        if (r[h]) begin
          r[h] = 0; e_clr[h] = 1;
        end else begin
          e_sel[h] = 1; e_evict = 1; found = 1;
        end
        h = (h + 1) % 4;
      end
      m_hand = h;
      e_lat  = 2 + s;
    end

    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; in_key = key; skey = keys; svld = vld; sref = rf;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 0; in_key = ~key; svld = ~vld; sref = ~rf;
    skey = {$urandom, $urandom, $urandom, $urandom};
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", lat, e_lat);
    check("sel", out_sel, e_sel);
    check("hit", out_hit, e_hit);
    check("evict", out_evict, e_evict);
    check("ref_clear", out_clr, e_clr);
    check("hand", dut.hand, 64'(m_hand));
    check("in_ready_busy", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_sel", out_sel, e_sel);
      check("hold_flags", {out_hit, out_evict, out_clr}, {e_hit, e_evict, e_clr});
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("released_valid", out_valid, 0);
    check("released_idle", in_ready, 1);
  endtask

  initial begin
    logic [3:0][31:0] kk;
    int lat3;

    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_outs", {out_sel, out_hit, out_evict, out_clr}, 0);
    check("rst_hand", dut.hand, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Hit on line 2
    kk[0] = 32'h1111; kk[1] = 32'h2222; kk[2] = 32'hCAFE; kk[3] = 32'h3333;
    lookup(32'hCAFE, kk, 4'b1111, 4'b0000, 0);
    // Miss with slot 2 free
    lookup(32'hDEAD, kk, 4'b1011, 4'b1111, 0);
    // Sweep from hand 0 clearing slots 0,1, victim slot 2
    lookup(32'hDEAD, kk, 4'b1111, 4'b0011, 0);
    // All refs set from hand 3: full lap, victim slot 3, hand wraps to 0
    lookup(32'hDEAD, kk, 4'b1111, 4'b1111, 0);
    // Duplicate matches on lines 1 and 3, consumer stalls 5 cycles
    kk[1] = 32'hBEEF; kk[3] = 32'hBEEF;
    lookup(32'hBEEF, kk, 4'b1111, 4'b0000, 5);

    // Reset in the middle of a sweep
    @(negedge clk);
    in_valid = 1; in_key = 32'h5555; skey = kk; svld = '1; sref = '1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_outs", {out_sel, out_hit, out_evict, out_clr}, 0);
    check("midrst_hand", dut.hand, 0);
    m_hand = 0;
    @(negedge clk);
    rst_n = 1;
    lookup(32'h5555, kk, 4'b1111, 4'b0010, 1);

    // Randomized lookups over a small key space so hits, frees and sweeps all occur
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) kk[k] = 32'($urandom_range(0, 7));
      lookup(32'($urandom_range(0, 7)), kk, 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    // Three-slot instance: refs 011 from hand 0 -> victim slot 2, hand wraps 2->0
    @(negedge clk);
    check("n3_in_ready", in_ready3, 1);
    in_valid3 = 1; in_key3 = 32'h77;
    skey3 = {32'h1, 32'h2, 32'h3}; svld3 = '1; sref3 = 3'b011;
    @(posedge clk);
    lat3 = 1;
    @(negedge clk);
    in_valid3 = 0; sref3 = '0;
    while (!out_valid3 && lat3 < 40) begin
      @(posedge clk); lat3++; @(negedge clk);
    end
    check("n3_latency", lat3, 5);
    check("n3_sel", out_sel3, 3'b100);
    check("n3_flags", {out_hit3, out_evict3}, 2'b01);
    check("n3_ref_clear", out_clr3, 3'b011);
    check("n3_hand", dut3.hand, 0);
    out_ready3 = 1;
    @(negedge clk);
    out_ready3 = 0;
    check("n3_released", {out_valid3, in_ready3}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/second_chance_select.md
Name: second_chance_select

Overview:
- Upstream stage of the second-chance bucket multiplexer. It drives that multiplexer's one-hot select.
- Accepts a lookup key plus the keys, valid bits and reference bits of all DATA_LINES x BUCKET_SIZE candidate slots, already read from the tables.
- On a hit: selects the matching slot.
- On a miss: selects a free slot, or runs a second-chance (clock-hand) sweep to choose a victim.
- Results are returned with a valid/ready handshake.

Parameters:
- KEY_WIDTH, 32, width of a key
- BUCKET_SIZE, 1, slots per table line
- DATA_LINES, 4, number of tables/lines examined per lookup
- (derived) N = DATA_LINES*BUCKET_SIZE; HAND_W = max(1, $clog2(N))

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_key  in  KEY_WIDTH  lookup key
- in_slot_key  in  [DATA_LINES-1:0][BUCKET_SIZE-1:0][KEY_WIDTH-1:0]  stored keys
- in_slot_valid  in  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  slot occupied
- in_slot_ref  in  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  second-chance reference bits
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sel  out  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  one-hot slot select (same [line][bucket] layout as the mux sel)
- out_hit  out  1  out_sel is a key match
- out_evict  out  1  out_sel is an occupied victim (miss, no free slot)
- out_ref_clear  out  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  reference bits cleared by the sweep, for write-back

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, hand=0.
  - out_valid=0, out_sel=0, out_hit=0, out_evict=0, out_ref_clear=0.
  - in_ready=1 once reset is released.
  - Asserting reset mid-sweep aborts the operation; no output is produced.
- Flat slot index k = line*BUCKET_SIZE + bucket. Lowest k has priority everywhere.
- States: IDLE, COMPARE, SWEEP, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid: register the key and all slot vectors, clear out_ref_clear, go to COMPARE.
  - COMPARE (one cycle):
    - match[k] = slot_valid[k] && slot_key[k]==key.
    - Any match: out_sel=onehot(lowest match), out_hit=1, go to DONE.
    - Else if any slot invalid: out_sel=onehot(lowest invalid), hit=0, evict=0, go to DONE.
    - Else go to SWEEP.
  - SWEEP (one slot per cycle, starting at hand):
    - If local ref[hand]=1: clear the local copy, set out_ref_clear[hand], hand=hand+1.
    - If local ref[hand]=0: out_sel=onehot(hand), out_evict=1, hand=hand+1, go to DONE.
    - hand wraps from N-1 to 0; N need not be a power of two.
    - Worst case N+1 cycles when all refs are set: the start slot is chosen on the second visit.
  - DONE:
    - out_valid=1; all outputs held stable until out_ready.
    - On out_valid && out_ready: go to IDLE, deassert out_valid.
- in_ready=1 only in IDLE. No overlap between operations; throughput is one lookup per at least 3 cycles.
- Latency from the accept edge to out_valid=1:
  - Hit or free slot: 2 cycles.
  - Sweep: 2 + s cycles, where s = slots examined (1..N+1).
- hand changes only in SWEEP and persists across operations.
- out_sel is always exactly one-hot while out_valid=1. out_hit and out_evict are never both 1.
- Input slot vectors are sampled only on the accept edge; later changes are ignored.

Decomposition:
- Package second_chance_pkg holds:
  - function onehot_lowest(vector) returning a one-hot vector
  - function index_to_onehot(idx, N)
  - state enum typedef
- One sub-module, sc_priority_onehot (parameter WIDTH), is used for both match and free-slot selection.
- Everything else lives in the top-level FSM.

Test Plan:
- All defaults, key=0xCAFE stored at line2, all valid -> out_valid 2 cycles after accept, out_sel=4'b0100, hit=1, evict=0, ref_clear=0.
- Key missing, slot valid=4'b1011 -> out_sel=4'b0100, hit=0, evict=0, latency 2.
- Miss, all valid, refs=4'b0011, hand=0 -> sweep 3 cycles, out_sel=4'b0100, evict=1, ref_clear=4'b0011, hand=3 afterwards.
- Miss, all valid, all refs=1, hand=3 -> sweep 5 cycles, out_sel=4'b1000, ref_clear=4'b1111, hand wraps to 0. Also run with DATA_LINES=3 to check wrap 2->0.
- Duplicate matches at line1 and line3 -> out_sel=4'b0010. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, then release -> IDLE.
- Assert rst_n=0 mid-sweep -> outputs 0 immediately, hand=0; next lookup behaves as from reset.
